// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: RV32M function
// select (funct3 encoding), controller state and small decode helpers.
package muldiv_unit_pkg;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_func_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_FIXUP = 2'd2,
      ST_DONE  = 2'd3
   } md_state_t;

   // Bit 1: rs1 is signed, bit 0: rs2 is signed.
   function automatic logic [1:0] op_signed(input md_func_t fn);
      logic [1:0] s;
      case (fn)
         MD_MUL, MD_MULH, MD_DIV, MD_REM: s = 2'b11;
         MD_MULHSU:                       s = 2'b10;
         default:                         s = 2'b00;
      endcase
      return s;
   endfunction

   // Division family occupies the upper half of the funct3 space.
   function automatic logic is_div_fn(input md_func_t fn);
      return fn[2];
   endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// One radix-2 iteration of the multiply/divide datapath.
// Multiply: acc = {partial_hi, multiplier}; conditional add then shift right.
// Divide:   acc = {remainder, dividend/quotient}; shift left, trial subtract,
//           restore on borrow and shift the quotient bit in at the bottom.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic                 div_mode,
   input  logic [2*WIDTH-1:0]   acc,
   input  logic [WIDTH-1:0]     opd,
   output logic [2*WIDTH-1:0]   acc_next
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;

   // Compute both candidate iterations and pick by mode.
   always_comb begin
      sum    = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + (acc[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
      rem_sh = acc[2*WIDTH-1:WIDTH-1];
      diff   = rem_sh - {1'b0, opd};
      if (div_mode) begin
         if (!diff[WIDTH]) begin
            acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         end else begin
            acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_next = {sum, acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are converted to
// magnitudes on accept, WIDTH radix-2 steps run in CALC, signs are
// reapplied in FIXUP and the tagged result is held in DONE until taken.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             kill,
   input  logic             req_valid,
   output logic             req_ready,
   input  md_func_t         req_fn,
   input  logic [WIDTH-1:0] req_in1,
   input  logic [WIDTH-1:0] req_in2,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic [TAG_W-1:0] resp_tag
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0]   ZERO  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]   ONES  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]   MINV  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [2*WIDTH-1:0] ZERO2 = {(2*WIDTH){1'b0}};
   localparam logic [CW-1:0]      CNT_LOAD = CW'(WIDTH - 1);

   md_state_t          state_r;
   logic [CW-1:0]      cnt_r;
   md_func_t           fn_r;
   logic [TAG_W-1:0]   tag_r;
   logic               sign1_r;
   logic               sign2_r;
   logic [2*WIDTH-1:0] acc_r;
   logic [WIDTH-1:0]   opd_r;
   logic [WIDTH-1:0]   resp_data_r;
   logic [TAG_W-1:0]   resp_tag_r;

   logic               sgn1_s;
   logic               sgn2_s;
   logic [WIDTH-1:0]   mag1_s;
   logic [WIDTH-1:0]   mag2_s;
   logic               div_zero_s;
   logic               ovf_s;
   logic               special_s;
   logic [WIDTH-1:0]   special_val_s;
   logic [2*WIDTH-1:0] acc_init_s;
   logic [WIDTH-1:0]   opd_init_s;
   logic [2*WIDTH-1:0] step_next_s;
   logic [2*WIDTH-1:0] prod_fix_s;
   logic [WIDTH-1:0]   quo_fix_s;
   logic [WIDTH-1:0]   rem_fix_s;
   logic [WIDTH-1:0]   fix_result_s;

   assign req_ready  = (state_r == ST_IDLE);
   assign resp_valid = (state_r == ST_DONE);
   assign resp_data  = resp_data_r;
   assign resp_tag   = resp_tag_r;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .div_mode (is_div_fn(fn_r)),
      .acc      (acc_r),
      .opd      (opd_r),
      .acc_next (step_next_s)
   );

   // Accept-side decode: signs, magnitudes and division special cases.
   always_comb begin
      sgn1_s     = op_signed(req_fn)[1] & req_in1[WIDTH-1];
      sgn2_s     = op_signed(req_fn)[0] & req_in2[WIDTH-1];
      mag1_s     = sgn1_s ? (ZERO - req_in1) : req_in1;
      mag2_s     = sgn2_s ? (ZERO - req_in2) : req_in2;
      div_zero_s = (req_in2 == ZERO);
      ovf_s      = ((req_fn == MD_DIV) || (req_fn == MD_REM))
                   && (req_in1 == MINV) && (req_in2 == ONES);
      special_s  = is_div_fn(req_fn) && (div_zero_s || ovf_s);
      case (req_fn)
         MD_DIV:  special_val_s = div_zero_s ? ONES : req_in1;
         MD_DIVU: special_val_s = ONES;
         MD_REM:  special_val_s = div_zero_s ? req_in1 : ZERO;
         MD_REMU: special_val_s = req_in1;
         default: special_val_s = ZERO;
      endcase
      // Multiply iterates over the multiplier in the low half; divide
      // shifts the dividend out of the low half.
      if (is_div_fn(req_fn)) begin
         acc_init_s = {ZERO, mag1_s};
         opd_init_s = mag2_s;
      end else begin
         acc_init_s = {ZERO, mag2_s};
         opd_init_s = mag1_s;
      end
   end

   // Sign restoration and result selection after the last iteration.
   always_comb begin
      prod_fix_s = (sign1_r ^ sign2_r) ? (ZERO2 - acc_r) : acc_r;
      quo_fix_s  = (sign1_r ^ sign2_r) ? (ZERO - acc_r[WIDTH-1:0])
                                       : acc_r[WIDTH-1:0];
      rem_fix_s  = sign1_r ? (ZERO - acc_r[2*WIDTH-1:WIDTH])
                           : acc_r[2*WIDTH-1:WIDTH];
      case (fn_r)
         MD_MUL:                       fix_result_s = prod_fix_s[WIDTH-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: fix_result_s = prod_fix_s[2*WIDTH-1:WIDTH];
         MD_DIV, MD_DIVU:              fix_result_s = quo_fix_s;
         MD_REM, MD_REMU:              fix_result_s = rem_fix_s;
         default:                      fix_result_s = ZERO;
      endcase
   end

   // Controller FSM with datapath and registered response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {CW{1'b0}};
         fn_r        <= MD_MUL;
         tag_r       <= {TAG_W{1'b0}};
         sign1_r     <= 1'b0;
         sign2_r     <= 1'b0;
         acc_r       <= ZERO2;
         opd_r       <= ZERO;
         resp_data_r <= ZERO;
         resp_tag_r  <= {TAG_W{1'b0}};
      end else if (kill) begin
         state_r <= ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  fn_r    <= req_fn;
                  tag_r   <= req_tag;
                  sign1_r <= sgn1_s;
                  sign2_r <= sgn2_s;
                  acc_r   <= acc_init_s;
                  opd_r   <= opd_init_s;
                  if (special_s) begin
                     resp_data_r <= special_val_s;
                     resp_tag_r  <= req_tag;
                     state_r     <= ST_DONE;
                  end else begin
                     cnt_r   <= CNT_LOAD;
                     state_r <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               acc_r <= step_next_s;
               if (cnt_r == {CW{1'b0}}) begin
                  state_r <= ST_FIXUP;
               end else begin
                  cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
               end
            end
            ST_FIXUP: begin
               resp_data_r <= fix_result_s;
               resp_tag_r  <= tag_r;
               state_r     <= ST_DONE;
            end
            ST_DONE: begin
               if (resp_ready) begin
                  state_r <= ST_IDLE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8, using an
// arithmetic reference model of the RV32M semantics.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        kill;
   // WIDTH=32 instance
   logic        req_valid, req_ready, resp_valid, resp_ready;
   md_func_t    req_fn;
   logic [31:0] req_in1, req_in2, resp_data;
   logic [4:0]  req_tag, resp_tag;
   // WIDTH=8 instance
   logic        req_valid_8, req_ready_8, resp_valid_8, resp_ready_8;
   md_func_t    req_fn_8;
   logic [7:0]  req_in1_8, req_in2_8, resp_data_8;
   logic [4:0]  req_tag_8, resp_tag_8;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32), .TAG_W(5)) dut32 (
      .clk(clk), .rst_n(rst_n), .kill(kill),
      .req_valid(req_valid), .req_ready(req_ready), .req_fn(req_fn),
      .req_in1(req_in1), .req_in2(req_in2), .req_tag(req_tag),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_tag(resp_tag));

   muldiv_unit #(.WIDTH(8), .TAG_W(5)) dut8 (
      .clk(clk), .rst_n(rst_n), .kill(kill),
      .req_valid(req_valid_8), .req_ready(req_ready_8), .req_fn(req_fn_8),
      .req_in1(req_in1_8), .req_in2(req_in2_8), .req_tag(req_tag_8),
      .resp_valid(resp_valid_8), .resp_ready(resp_ready_8),
      .resp_data(resp_data_8), .resp_tag(resp_tag_8));

   // Reference: RV32M semantics at width w using 64-bit integer arithmetic.
   function automatic longint unsigned ref_model(input int w, input int fn,
                                                 input longint unsigned a,
                                                 input longint unsigned b);
      longint unsigned mask, r;
      longint sa, sb, minv;
      mask = (64'd1 << w) - 64'd1;
      sa   = a[w-1] ? (longint'(a) - longint'(64'd1 << w)) : longint'(a);
      sb   = b[w-1] ? (longint'(b) - longint'(64'd1 << w)) : longint'(b);
      minv = -(longint'(64'd1 << (w-1)));
      r    = 64'd0;
      case (fn)
         0: r = longint'(sa * sb);
         1: r = longint'((sa * sb) >>> w);
         2: r = longint'((sa * longint'(b)) >>> w);
         3: r = (a * b) >> w;
         4: begin
            if (b == 0) r = mask;
            else if (sa == minv && sb == -1) r = a;
            else r = longint'(sa / sb);
         end
         5: begin
            if (b == 0) r = mask;
            else r = a / b;
         end
         6: begin
            if (b == 0) r = a;
            else if (sa == minv && sb == -1) r = 64'd0;
            else r = longint'(sa % sb);
         end
         default: begin
            if (b == 0) r = a;
            else r = a % b;
         end
      endcase
      return r & mask;
   endfunction

   // Expected cycles from accept to first resp_valid.
   function automatic int exp_lat(input int w, input int fn,
                                  input longint unsigned a, input longint unsigned b);
      longint unsigned minu, onesu;
      minu  = 64'd1 << (w-1);
      onesu = (64'd1 << w) - 64'd1;
      if (fn >= 4 && b == 0) return 1;
      if ((fn == 4 || fn == 6) && a == minu && b == onesu) return 1;
      return w + 2;
   endfunction

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Issue one request to the 32-bit unit and wait for its response.
   task automatic op32(input md_func_t fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output logic [31:0] d,
                       output logic [4:0] t, output int lat);
      @(negedge clk);
      req_fn = fn; req_in1 = a; req_in2 = b; req_tag = tag; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      d = resp_data; t = resp_tag;
      if (resp_ready && resp_valid) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic op8(input md_func_t fn, input logic [7:0] a, input logic [7:0] b,
                      input logic [4:0] tag, output logic [7:0] d,
                      output logic [4:0] t, output int lat);
      @(negedge clk);
      req_fn_8 = fn; req_in1_8 = a; req_in2_8 = b; req_tag_8 = tag; req_valid_8 = 1'b1;
      @(posedge clk); #1;
      req_valid_8 = 1'b0;
      lat = 1;
      while (!resp_valid_8 && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      d = resp_data_8; t = resp_tag_8;
      if (resp_valid_8) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
      n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
      n_cmp++; if (resp_data !== 32'h0) begin n_bad++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
      n_cmp++; if (resp_tag !== 5'h0) begin n_bad++; $display("FAIL reset_resp_tag: got %h expected 0", resp_tag); end
      n_cmp++; if (req_ready_8 !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready_8: got %b expected 1", req_ready_8); end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      md_func_t    fns [12] = '{MD_MUL, MD_MULH, MD_MULHU, MD_MULHSU, MD_DIVU, MD_REMU,
                                MD_DIV, MD_REM, MD_DIV, MD_REM, MD_DIV, MD_REM};
      logic [31:0] as  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100,
                                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd1234, 32'd1234, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd7,
                                32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] ex  [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1234, 32'h8000_0000, 32'd0};
      int          lx  [12] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1};
      logic [31:0] d; logic [4:0] t; int lat;
      for (int i = 0; i < 12; i++) begin
         op32(fns[i], as[i], bs[i], 5'(i + 3), d, t, lat);
         n_cmp++; if (d !== ex[i]) begin n_bad++; $display("FAIL dir_data[%0d]: got %h expected %h", i, d, ex[i]); end
         n_cmp++; if (t !== 5'(i + 3)) begin n_bad++; $display("FAIL dir_tag[%0d]: got %0d expected %0d", i, t, i + 3); end
         n_cmp++; if (lat != lx[i]) begin n_bad++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, lx[i]); end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, d; logic [4:0] t, tg; int lat, fn;
      longint unsigned e;
      for (int i = 0; i < 60; i++) begin
         fn = $urandom_range(0, 7);
         a = pick32(); b = pick32(); tg = 5'($urandom);
         op32(md_func_t'(3'(fn)), a, b, tg, d, t, lat);
         e = ref_model(32, fn, {32'h0, a}, {32'h0, b});
         n_cmp++; if (d !== e[31:0]) begin n_bad++; $display("FAIL rand_data fn=%0d a=%h b=%h: got %h expected %h", fn, a, b, d, e[31:0]); end
         n_cmp++; if (t !== tg) begin n_bad++; $display("FAIL rand_tag: got %0d expected %0d", t, tg); end
         n_cmp++; if (lat != exp_lat(32, fn, {32'h0, a}, {32'h0, b})) begin n_bad++; $display("FAIL rand_latency fn=%0d: got %0d", fn, lat); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] d0; logic [4:0] t0; int lat;
      resp_ready = 1'b0;
      op32(MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21, d0, t0, lat);
      n_cmp++; if (d0 !== 32'h0B00_EA4E) begin n_bad++; $display("FAIL bp_data: got %h expected 0b00ea4e", d0); end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n_cmp++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_flags[%0d]: got valid=%b ready=%b expected 1/0", i, resp_valid, req_ready); end
         n_cmp++; if (resp_data !== d0 || resp_tag !== 5'd21) begin n_bad++; $display("FAIL bp_hold[%0d]: got %h/%0d expected %h/21", i, resp_data, resp_tag, d0); end
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", resp_valid, req_ready); end
   endtask

   task automatic test_kill();
      logic [31:0] d; logic [4:0] t; int lat; logic saw;
      longint unsigned e;
      @(negedge clk);
      req_fn = MD_DIVU; req_in1 = 32'd999; req_in2 = 32'd10; req_tag = 5'd9; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (11) begin @(posedge clk); #1; end
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL kill_idle: got ready=%b valid=%b expected 1/0", req_ready, resp_valid); end
      // A request presented together with kill must not be taken.
      @(negedge clk);
      req_valid = 1'b1; kill = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; kill = 1'b0;
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL kill_blocks_accept: got ready=%b expected 1", req_ready); end
      saw = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (resp_valid) saw = 1'b1; end
      n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL kill_no_resp: got %b expected 0", saw); end
      op32(MD_REM, 32'hFFFF_FC00, 32'd7, 5'd17, d, t, lat);
      e = ref_model(32, 6, 64'hFFFF_FC00, 64'd7);
      n_cmp++; if (d !== e[31:0] || t !== 5'd17 || lat != 34) begin n_bad++; $display("FAIL kill_fresh: got %h/%0d/%0d expected %h/17/34", d, t, lat, e[31:0]); end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      req_fn = MD_MUL; req_in1 = 32'd5; req_in2 = 32'd6; req_tag = 5'd4; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL areset_flags: got ready=%b valid=%b expected 1/0", req_ready, resp_valid); end
      n_cmp++; if (resp_data !== 32'h0 || resp_tag !== 5'h0) begin n_bad++; $display("FAIL areset_outputs: got %h/%0d expected 0/0", resp_data, resp_tag); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_width8();
      logic [7:0] a, b, d; logic [4:0] t, tg; int lat, fn;
      longint unsigned e;
      for (int i = 0; i < 64; i++) begin
         fn = i % 8;
         case ($urandom_range(0, 4))
            0: a = 8'h80;
            1: a = 8'hFF;
            default: a = 8'($urandom);
         endcase
         case ($urandom_range(0, 4))
            0: b = 8'h00;
            1: b = 8'hFF;
            default: b = 8'($urandom);
         endcase
         tg = 5'($urandom);
         op8(md_func_t'(3'(fn)), a, b, tg, d, t, lat);
         e = ref_model(8, fn, {56'h0, a}, {56'h0, b});
         n_cmp++; if (d !== e[7:0]) begin n_bad++; $display("FAIL w8_data fn=%0d a=%h b=%h: got %h expected %h", fn, a, b, d, e[7:0]); end
         n_cmp++; if (t !== tg) begin n_bad++; $display("FAIL w8_tag: got %0d expected %0d", t, tg); end
         n_cmp++; if (lat != exp_lat(8, fn, {56'h0, a}, {56'h0, b})) begin n_bad++; $display("FAIL w8_latency fn=%0d: got %0d", fn, lat); end
      end
   endtask

   initial begin
      rst_n = 1'b0; kill = 1'b0;
      req_valid = 1'b0; req_fn = MD_MUL; req_in1 = 32'h0; req_in2 = 32'h0; req_tag = 5'h0;
      resp_ready = 1'b1;
      req_valid_8 = 1'b0; req_fn_8 = MD_MUL; req_in1_8 = 8'h0; req_in2_8 = 8'h0; req_tag_8 = 5'h0;
      resp_ready_8 = 1'b1;
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_kill();
      test_async_reset();
      test_width8();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit for the execute stage, implementing the full RV32M operation set (mul, mulh, mulhsu, mulhu, div, divu, rem, remu) at a configurable datapath width. It sits beside the single-cycle ALU and handles all M-extension micro-ops. Operands enter through a valid/ready request port; tagged results leave through a valid/ready response port. A kill input discards in-flight work on a pipeline flush.

## Interface
- WIDTH, 32: operand and result width in bits; must be ≥ 4.
- TAG_W, 5: width of the opaque tag carried from request to response.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- kill  in  1  flush; abandons any in-flight operation.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_fn  in  mdfnt::md_func_t  operation select.
- req_in1  in  WIDTH  rs1 operand (multiplicand or dividend).
- req_in2  in  WIDTH  rs2 operand (multiplier or divisor).
- req_tag  in  TAG_W  tag, returned unchanged with the result.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  WIDTH  result.
- resp_tag  out  TAG_W  tag of the result.

## Operation
- **FSM states:** IDLE, CALC, FIXUP, DONE.
- **IDLE:**
  - req_ready=1.
  - On req_valid && !kill, the unit latches fn and tag, records the operand signs per fn, and stores the operand absolute values.
  - mulhsu treats in2 as unsigned. mulhu, divu and remu treat both operands as unsigned.
  - Next state is CALC, except for the division special cases below.
- **CALC:**
  - The unit performs WIDTH radix-2 iterations, counted by a $clog2(WIDTH)-bit counter that loads WIDTH-1 and moves to FIXUP at 0.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring division producing a WIDTH-bit quotient and a WIDTH-bit remainder.
- **FIXUP:**
  - Product sign = sign1 XOR sign2 (two's-complement negate on the full 2·WIDTH accumulator).
  - Quotient sign = sign1 XOR sign2.
  - Remainder sign = sign1 (dividend sign).
  - Result select: mul takes the low WIDTH bits; mulh, mulhsu and mulhu take the high WIDTH bits.
  - Next state is DONE.
- **DONE:**
  - resp_valid=1; resp_data and resp_tag are held stable until resp_valid && resp_ready.
  - On that handshake the unit returns to IDLE.
  - req_ready stays 0 in DONE. There is no accept in the same cycle as the response.
- **Division special cases** (decided in IDLE; the unit goes straight to DONE):
  - Divide by zero: div and divu return all-ones; rem and remu return in1.
  - Signed overflow (in1 = most-negative value, in2 = −1): div returns in1; rem returns 0.
- **kill:**
  - In any state, the next state is IDLE and resp_valid drops the next cycle. The result is lost and no response is produced.
  - kill in the same cycle as req_valid blocks the accept.
- **Reset** (rst_n low, asynchronous):
  - State becomes IDLE and the counter 0.
  - resp_valid=0, resp_data=0, resp_tag=0, req_ready=1. req_ready is driven by state, so it reads 1 while reset is asserted.
  - Reset mid-operation discards all work.

## Timing
- Request accepted at edge T (cycle 0).
  - Normal operation: CALC occupies cycles 1..WIDTH, FIXUP is cycle WIDTH+1, and resp_valid first goes high in cycle WIDTH+2 (34 for WIDTH=32).
  - Special case: resp_valid goes high in cycle 1.
- Throughput: one operation every WIDTH+3 cycles at best (response consumed in its first valid cycle, then one IDLE cycle to accept).
- req_ready and resp_valid are purely functions of the state register, with no combinational path from any input.
- resp_ready low: the unit stalls in DONE indefinitely and all outputs are held.

## Structure
- Add mdfnt::md_func_t, a 3-bit enum matching funct3 encoding (mul=0 … remu=7), to the ctrl_sigs package alongside alufnt.
- Add the state enum md_state_t to the same package.
- One natural sub-module: muldiv_step, combinational, a single radix-2 iteration parametrised by WIDTH.
  - Multiply mode: conditional add and shift.
  - Divide mode: trial subtract, quotient bit, restore.
  - muldiv_unit instantiates it once and registers its outputs each CALC cycle.

## Test plan
- **mul:** in1=7, in2=0xFFFFFFFD, tag=3 → resp_valid in cycle 34, resp_data=0xFFFFFFEB, resp_tag=3.
- **mulh / mulhu:** mulh 0x80000000×0x80000000 → 0x40000000; mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; mulhsu 0xFFFFFFFF×2 → 0xFFFFFFFF.
- **divide family:** divu 100/7 → 14; remu 100%7 → 2; div −7/2 → 0xFFFFFFFD; rem −7%2 → 0xFFFFFFFF.
- **special cases:** div x/0 → 0xFFFFFFFF and rem x/0 → x, both valid in cycle 1; div 0x80000000/−1 → 0x80000000 and rem → 0.
- **backpressure and kill:**
  - resp_ready held low 10 cycles → data and tag stable, req_ready=0.
  - kill in cycle 12 of CALC → IDLE next cycle and no resp_valid; a fresh request is then accepted and completes correctly.
- **reset and width:**
  - rst_n pulsed low mid-CALC, asynchronous to clk → outputs reset immediately, req_ready=1.
  - Rerun all scenarios at WIDTH=8 against a reference model (latency 10).
